// File: rtl/seri_toplama_cikarma.sv
//------------------------------------------------------------------------------
// Module   : seri_toplama_cikarma
// Brief    : Serial signed adder/subtractor, STEP bits per clock, W+1-bit exact
//            result aligned to Q(2W-2FRAC).2FRAC. Optional macro: SATURATION_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module seri_toplama_cikarma #(
   parameter int W    = 32,
   parameter int FRAC = 16,
   parameter int STEP = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             basla,
   input  logic             islem,
   input  logic [W-1:0]     sayi1,
   input  logic [W-1:0]     sayi2,
   output logic [2*W-1:0]   sonuc,
   output logic             hazir,
   output logic             gecerli,
   output logic             tasma
);

   localparam int NSTEP = W / STEP;
   localparam int CW    = $clog2(NSTEP + 1);

   typedef enum logic [0:0] {
      BOSTA = 1'b0,
      HESAP = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [W-1:0]     a_q, a_d, b_q, b_d, sum_q, sum_d;
   logic             carry_q, carry_d;
   logic             a_msb_q, a_msb_d, b_msb_q, b_msb_d;
   logic             gecerli_q, gecerli_d, tasma_q, tasma_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [2*W-1:0]   sonuc_q, sonuc_d;

   logic [STEP:0]    w_slice;
   logic [W-1:0]     w_sum_shift;
   logic [W-1:0]     w_b_in;
   logic [W:0]       w_r;
   logic             w_ovf;
   logic [2*W-1:0]   w_ext;

   assign w_slice = {1'b0, a_q[STEP-1:0]} + {1'b0, b_q[STEP-1:0]} + {{STEP{1'b0}}, carry_q};

   // New sum bits enter from the MSB side so the word is LSB-aligned after the last step.
   generate
      if (STEP == W) begin : g_full
         assign w_sum_shift = w_slice[STEP-1:0];
      end else begin : g_part
         assign w_sum_shift = {w_slice[STEP-1:0], sum_q[W-1:STEP]};
      end
   endgenerate

   assign w_b_in = islem ? ~sayi2 : sayi2;
   assign w_ovf  = (a_msb_q == b_msb_q) && (w_sum_shift[W-1] != a_msb_q);

   always_comb begin
      w_r = {a_msb_q ^ b_msb_q ^ w_slice[STEP], w_sum_shift};
`ifdef SATURATION_EN
      if (w_ovf) begin
         w_r = a_msb_q ? {2'b11, {(W-1){1'b0}}} : {2'b00, {(W-1){1'b1}}};
      end
`endif
      w_ext = {{(W-1){w_r[W]}}, w_r} << FRAC;
   end

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      sum_d     = sum_q;
      carry_d   = carry_q;
      a_msb_d   = a_msb_q;
      b_msb_d   = b_msb_q;
      cnt_d     = cnt_q;
      gecerli_d = gecerli_q;
      tasma_d   = tasma_q;
      sonuc_d   = sonuc_q;
      case (state_q)
         BOSTA: begin
            if (basla) begin
               a_d       = sayi1;
               b_d       = w_b_in;
               a_msb_d   = sayi1[W-1];
               b_msb_d   = w_b_in[W-1];
               carry_d   = islem;
               cnt_d     = '0;
               gecerli_d = 1'b0;
               state_d   = HESAP;
            end
         end
         HESAP: begin
            sum_d   = w_sum_shift;
            a_d     = a_q >> STEP;
            b_d     = b_q >> STEP;
            carry_d = w_slice[STEP];
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == CW'(NSTEP - 1)) begin
               sonuc_d   = w_ext;
               tasma_d   = w_ovf;
               gecerli_d = 1'b1;
               state_d   = BOSTA;
            end
         end
         default: state_d = BOSTA;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= BOSTA;
         a_q       <= '0;
         b_q       <= '0;
         sum_q     <= '0;
         carry_q   <= 1'b0;
         a_msb_q   <= 1'b0;
         b_msb_q   <= 1'b0;
         cnt_q     <= '0;
         gecerli_q <= 1'b0;
         tasma_q   <= 1'b0;
         sonuc_q   <= '0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         b_q       <= b_d;
         sum_q     <= sum_d;
         carry_q   <= carry_d;
         a_msb_q   <= a_msb_d;
         b_msb_q   <= b_msb_d;
         cnt_q     <= cnt_d;
         gecerli_q <= gecerli_d;
         tasma_q   <= tasma_d;
         sonuc_q   <= sonuc_d;
      end
   end

   assign hazir   = (state_q == BOSTA);
   assign gecerli = gecerli_q;
   assign tasma   = tasma_q;
   assign sonuc   = sonuc_q;

endmodule

`default_nettype wire

// File: tb/tb_seri_toplama_cikarma.sv
//------------------------------------------------------------------------------
// Module   : tb_seri_toplama_cikarma
// Brief    : Self-checking bench for seri_toplama_cikarma (STEP=1 and STEP=4).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_seri_toplama_cikarma;

   typedef struct {
      logic [63:0] sonuc;
      logic        tasma;
   } exp_t;

   typedef struct {
      logic        isl;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] es;
      logic        et;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic basla = 1'b0, islem = 1'b0;
   logic [31:0] sayi1 = '0, sayi2 = '0;
   logic [63:0] sonuc;
   logic hazir, gecerli, tasma;

   logic basla4 = 1'b0, islem4 = 1'b0;
   logic [31:0] sayi1_4 = '0, sayi2_4 = '0;
   logic [63:0] sonuc4;
   logic hazir4, gecerli4, tasma4;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   exp_t q1[$];
   exp_t q4[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   seri_toplama_cikarma #(.W(32), .FRAC(16), .STEP(1)) dut (
      .clk(clk), .rst(rst), .basla(basla), .islem(islem), .sayi1(sayi1), .sayi2(sayi2),
      .sonuc(sonuc), .hazir(hazir), .gecerli(gecerli), .tasma(tasma));

   seri_toplama_cikarma #(.W(32), .FRAC(16), .STEP(4)) dut4 (
      .clk(clk), .rst(rst), .basla(basla4), .islem(islem4), .sayi1(sayi1_4), .sayi2(sayi2_4),
      .sonuc(sonuc4), .hazir(hazir4), .gecerli(gecerli4), .tasma(tasma4));

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic exp_t model(input logic isl, input logic [31:0] a, input logic [31:0] b);
      exp_t   e;
      longint sa, sb, r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      r  = isl ? sa - sb : sa + sb;
      e.tasma = (r > 64'sd2147483647) || (r < -64'sd2147483648);
`ifdef SATURATION_EN
      if (e.tasma) r = (r > 0) ? 64'sd2147483647 : -64'sd2147483648;
`endif
      e.sonuc = 64'(r <<< 16);
      return e;
   endfunction

   // Drives one request on dut, waits for acceptance; returns the accept cycle.
   task automatic start_op(input logic isl, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] es, input logic et, output int acc);
      exp_t e;
      int   guard;
      guard = 0;
      while (!hazir && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      @(negedge clk);
      basla = 1'b1; islem = isl; sayi1 = a; sayi2 = b;
      e.sonuc = es; e.tasma = et;
      q1.push_back(e);
      @(posedge clk);
      acc = cyc + 1;
      @(negedge clk);
      basla = 1'b0;
      check("accept_hazir_low", 64'(hazir), 64'd0);
   endtask

   task automatic wait_check(input string name, input int acc);
      exp_t e;
      int   guard;
      guard = 0;
      while (guard < 100) begin
         @(posedge clk);
         #1;
         guard++;
         if (gecerli) break;
      end
      e = q1.pop_front();
      check({name, "_latency"}, 64'(cyc - acc), 64'd32);
      check({name, "_sonuc"}, sonuc, e.sonuc);
      check({name, "_tasma"}, 64'(tasma), 64'(e.tasma));
      check({name, "_hazir"}, 64'(hazir), 64'd1);
   endtask

   initial begin
      vec_t vt[8];
      int   acc, acc2, hz;
      exp_t e;

      vt[0] = '{1'b0, 32'h00018000, 32'h00024000, 64'h00000003C0000000, 1'b0};
      vt[1] = '{1'b1, 32'h00010000, 32'h00028000, 64'hFFFFFFFE80000000, 1'b0};
`ifdef SATURATION_EN
      vt[2] = '{1'b0, 32'h7FFF0000, 32'h00010000, 64'h00007FFFFFFF0000, 1'b1};
      vt[3] = '{1'b1, 32'h80000000, 32'h00000001, 64'hFFFF800000000000, 1'b1};
`else
      vt[2] = '{1'b0, 32'h7FFF0000, 32'h00010000, 64'h0000800000000000, 1'b1};
      vt[3] = '{1'b1, 32'h80000000, 32'h00000001, 64'hFFFF7FFFFFFF0000, 1'b1};
`endif
      vt[4] = '{1'b1, 32'h80000000, 32'h80000000, 64'h0, 1'b0};
      vt[5] = '{1'b0, 32'hFFFFFFFF, 32'h00000001, 64'h0, 1'b0};
      vt[6] = '{1'b1, 32'h7FFFFFFF, 32'hFFFFFFFF, 64'h0, 1'b0};
      vt[7] = '{1'b0, $urandom, $urandom, 64'h0, 1'b0};
      for (int i = 4; i < 8; i++) begin
         e = model(vt[i].isl, vt[i].a, vt[i].b);
         vt[i].es = e.sonuc;
         vt[i].et = e.tasma;
      end

      #12;
      check("reset_hazir", 64'(hazir), 64'd1);
      check("reset_gecerli", 64'(gecerli), 64'd0);
      check("reset_tasma", 64'(tasma), 64'd0);
      check("reset_sonuc", sonuc, 64'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 8; i++) begin
         start_op(vt[i].isl, vt[i].a, vt[i].b, vt[i].es, vt[i].et, acc);
         wait_check($sformatf("vec%0d", i), acc);
      end

      // Request during a busy operation must be ignored.
      start_op(1'b0, 32'h00018000, 32'h00024000, 64'h00000003C0000000, 1'b0, acc);
      repeat (5) @(negedge clk);
      basla = 1'b1; islem = 1'b1; sayi1 = 32'h12345678; sayi2 = 32'h00ABCDEF;
      @(negedge clk);
      basla = 1'b0;
      check("busy_gecerli_stale", 64'(gecerli), 64'd0);
      wait_check("busy_ignore", acc);
      repeat (3) @(negedge clk);
      check("hold_sonuc", sonuc, 64'h00000003C0000000);
      check("hold_gecerli", 64'(gecerli), 64'd1);

      // Reset mid-operation aborts without exposing anything.
      start_op(1'b0, 32'h7FFF0000, 32'h00010000, 64'h0, 1'b0, acc);
      repeat (10) @(negedge clk);
      rst = 1'b1;
      #1;
      void'(q1.pop_front());
      check("midrst_hazir", 64'(hazir), 64'd1);
      check("midrst_gecerli", 64'(gecerli), 64'd0);
      check("midrst_sonuc", sonuc, 64'd0);
      check("midrst_tasma", 64'(tasma), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      start_op(1'b0, 32'h00018000, 32'h00024000, 64'h00000003C0000000, 1'b0, acc);
      wait_check("after_rst", acc);

      // STEP=4: latency 8 and back-to-back with basla held high.
      @(negedge clk);
      basla4 = 1'b1; islem4 = 1'b0; sayi1_4 = 32'h00018000; sayi2_4 = 32'h00024000;
      e.sonuc = 64'h00000003C0000000; e.tasma = 1'b0;
      q4.push_back(e);
      q4.push_back(e);
      @(posedge clk);
      acc = cyc + 1;
      acc2 = 0;
      hz = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk);
         #1;
         if (hazir4) hz++;
         if (gecerli4 && acc2 == 0) begin
            acc2 = cyc;
            e = q4.pop_front();
            check("s4_latency", 64'(acc2 - acc), 64'd8);
            check("s4_sonuc", sonuc4, e.sonuc);
            check("s4_tasma", 64'(tasma4), 64'(e.tasma));
         end
         if (acc2 != 0 && !hazir4) break;
      end
      check("s4_b2b_hazir_cycles", 64'(hz), 64'd1);
      check("s4_b2b_reaccepted", 64'(hazir4), 64'd0);
      @(negedge clk);
      basla4 = 1'b0;
      acc = cyc;
      acc2 = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk);
         #1;
         if (gecerli4) begin
            acc2 = cyc;
            break;
         end
      end
      e = q4.pop_front();
      check("s4_second_done", 64'(acc2 != 0), 64'd1);
      check("s4_second_sonuc", sonuc4, e.sonuc);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
